// File: rtl/lsu_mc.sv
// lsu_mc: multi-cycle load/store unit with an internal word-organised data memory.
//
// A request is accepted with a valid/ready handshake. Errors are decoded when the
// request is accepted: an illegal funct3, or any accessed byte beyond the memory.
// An error goes straight to the response and leaves memory untouched.
// Each memory word access takes 1+WAIT_CYCLES cycles. busy_o stalls the core.
//
// Parameters:
//   ADDR_W       byte-address width
//   DEPTH_WORDS  number of 32-bit memory words (power of two, >= 2)
//   WAIT_CYCLES  extra stall cycles per word access (0..15)
//
// Ports:
//   clk_i, rst_i            clock; synchronous active-high reset
//   req_valid_i/ready_o     request handshake
//   req_we_i                1 = store, 0 = load
//   req_funct3_i            RV32I load/store funct3
//   req_addr_i              byte address
//   req_wdata_i             store data
//   rsp_valid_o             one-cycle completion pulse
//   rsp_rdata_o             extended load data (0 for stores and errors)
//   rsp_err_o               access rejected (valid with rsp_valid_o)
//   busy_o                  unit is not idle
//
// Optional feature macro: LSU_MISALIGN_SPLIT_EN
//   defined   - an access crossing a word boundary is split over two word accesses
//   undefined - a misaligned halfword or word access is an error
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request; decode and error check on acceptance
// ACC0  | wait, then access the word holding the lowest addressed byte
// ACC1  | wait, then access the following word (split accesses only)
// RESP  | one-cycle response pulse

module lsu_mc #(
   parameter int ADDR_W      = 32,
   parameter int DEPTH_WORDS = 512,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [2:0]        req_funct3_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              rsp_valid_o,
   output logic [31:0]       rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              busy_o
);

   localparam int              IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(4 * DEPTH_WORDS);
   localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC0 = 2'd1,
      S_ACC1 = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic             we_q;
   logic [2:0]       f3_q;
   logic [1:0]       off_q;
   logic [IDX_W-1:0] idx_q;
   logic [7:0]       mask_q;
   logic [63:0]      wdata_q;
   logic             err_q;
   logic             cross_q;
   logic [3:0]       wait_q;
   // Bytes of the (up to) two accessed words. The top byte of the second word
   // can never be part of an access, so it is not kept.
   logic [55:0]      rword_q;

   logic        accept;
   logic        acc_active;
   logic        acc_fire;

   logic [2:0]        nbytes;
   logic [3:0]        size_mask;
   logic              f3_legal;
   logic [ADDR_W:0]   last_addr;
   logic              range_err;
   logic              align_err;
   logic              req_err;
   logic [3:0]        span;
   logic              req_cross;
   logic [7:0]        req_mask;
   logic [63:0]       req_wdata_sh;

   logic [31:0]       mem_q [DEPTH_WORDS];
   logic [IDX_W-1:0]  mem_idx;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wd;
   logic              mem_we;
   logic [31:0]       mem_rdata;

   logic [31:0]       ld_raw;
   logic [31:0]       ld_ext;

   assign accept     = req_valid_i && req_ready_o;
   assign acc_active = (state_q == S_ACC0) || (state_q == S_ACC1);
   assign acc_fire   = acc_active && (wait_q == 4'd0);

   // Request decode, evaluated on the live request inputs.
   always_comb begin
      case (req_funct3_i[1:0])
         2'b00:   begin nbytes = 3'd1; size_mask = 4'b0001; end
         2'b01:   begin nbytes = 3'd2; size_mask = 4'b0011; end
         default: begin nbytes = 3'd4; size_mask = 4'b1111; end
      endcase

      if (req_we_i) begin
         f3_legal = !req_funct3_i[2] && (req_funct3_i[1:0] != 2'b11);
      end else begin
         f3_legal = (req_funct3_i[1:0] != 2'b11) && (req_funct3_i[2:1] != 2'b11);
      end

      // One extra bit so an access wrapping past the top of the address space
      // still reads as out of range.
      last_addr = {1'b0, req_addr_i} + (ADDR_W + 1)'(nbytes) - (ADDR_W + 1)'(1);
      range_err = last_addr >= MEM_BYTES;

      span      = {2'b00, req_addr_i[1:0]} + {1'b0, nbytes};
      req_cross = span > 4'd4;

`ifdef LSU_MISALIGN_SPLIT_EN
      align_err = 1'b0;
`else
      align_err = ((nbytes == 3'd2) && req_addr_i[0]) ||
                  ((nbytes == 3'd4) && (req_addr_i[1:0] != 2'b00));
`endif

      req_err = !f3_legal || range_err || align_err;

      // Low nibble = lanes of the first word, high nibble = lanes of the next word.
      req_mask     = {4'b0000, size_mask} << req_addr_i[1:0];
      req_wdata_sh = {32'h0, req_wdata_i} << {req_addr_i[1:0], 3'b000};
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = req_err ? S_RESP : S_ACC0;
            end
         end
         S_ACC0: begin
            if (acc_fire) begin
               state_d = cross_q ? S_ACC1 : S_RESP;
            end
         end
         S_ACC1: begin
            if (acc_fire) begin
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      req_ready_o = 1'b0;
      busy_o      = 1'b1;
      rsp_valid_o = 1'b0;
      rsp_err_o   = 1'b0;
      rsp_rdata_o = 32'h0;
      case (state_q)
         S_IDLE: begin
            req_ready_o = 1'b1;
            busy_o      = 1'b0;
         end
         S_RESP: begin
            rsp_valid_o = 1'b1;
            rsp_err_o   = err_q;
            if (!err_q && !we_q) begin
               rsp_rdata_o = ld_ext;
            end
         end
         default: ;
      endcase
   end

   // Request capture, wait down-counter and read-word capture.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         off_q   <= 2'b00;
         idx_q   <= '0;
         mask_q  <= 8'h00;
         wdata_q <= 64'h0;
         err_q   <= 1'b0;
         cross_q <= 1'b0;
         wait_q  <= 4'd0;
         rword_q <= 56'h0;
      end else if (accept) begin
         we_q    <= req_we_i;
         f3_q    <= req_funct3_i;
         off_q   <= req_addr_i[1:0];
         idx_q   <= req_addr_i[IDX_W+1:2];
         mask_q  <= req_mask;
         wdata_q <= req_wdata_sh;
         err_q   <= req_err;
         cross_q <= req_cross;
         wait_q  <= WAIT_INIT;
         rword_q <= 56'h0;
      end else if (acc_active) begin
         if (wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
         end else begin
            // Reload so ACC1 gets the same number of wait cycles as ACC0.
            wait_q <= WAIT_INIT;
            if (state_q == S_ACC0) begin
               rword_q[31:0] <= mem_rdata;
            end else begin
               rword_q[55:32] <= mem_rdata[23:0];
            end
         end
      end
   end

   // Memory port: ACC0 addresses the first word, ACC1 the one after it.
   always_comb begin
      if (state_q == S_ACC1) begin
         mem_idx = idx_q + IDX_W'(1);
         mem_be  = mask_q[7:4];
         mem_wd  = wdata_q[63:32];
      end else begin
         mem_idx = idx_q;
         mem_be  = mask_q[3:0];
         mem_wd  = wdata_q[31:0];
      end
      mem_we    = acc_fire && we_q;
      mem_rdata = mem_q[mem_idx];
   end

   // Memory contents are never reset; a reset on the same edge as a pending
   // write aborts that write.
   always_ff @(posedge clk_i) begin
      if (mem_we && !rst_i) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_be[i]) begin
               mem_q[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
            end
         end
      end
   end

   // Load alignment and extension: pick the four bytes starting at the offset.
   always_comb begin
      case (off_q)
         2'd0:    ld_raw = rword_q[31:0];
         2'd1:    ld_raw = rword_q[39:8];
         2'd2:    ld_raw = rword_q[47:16];
         default: ld_raw = rword_q[55:24];
      endcase
      case (f3_q)
         3'b000:  ld_ext = {{24{ld_raw[7]}}, ld_raw[7:0]};
         3'b001:  ld_ext = {{16{ld_raw[15]}}, ld_raw[15:0]};
         3'b100:  ld_ext = {24'h0, ld_raw[7:0]};
         3'b101:  ld_ext = {16'h0, ld_raw[15:0]};
         default: ld_ext = ld_raw;
      endcase
   end

endmodule

// File: tb/tb_lsu_mc.sv
// Bench for lsu_mc: a WAIT_CYCLES=0 instance for function, error and reset
// cases, and a WAIT_CYCLES=3 instance for handshake timing.
module tb_lsu_mc;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_w0, valid_w3;
   logic        we;
   logic [2:0]  f3;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic        ready_w0, rsp_v_w0, err_w0, busy_w0;
   logic [31:0] rdata_w0;
   logic        ready_w3, rsp_v_w3, err_w3, busy_w3;
   logic [31:0] rdata_w3;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   lsu_mc #(.ADDR_W(32), .DEPTH_WORDS(512), .WAIT_CYCLES(0)) u_dut_w0 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(valid_w0), .req_ready_o(ready_w0),
      .req_we_i(we), .req_funct3_i(f3), .req_addr_i(addr), .req_wdata_i(wdata),
      .rsp_valid_o(rsp_v_w0), .rsp_rdata_o(rdata_w0), .rsp_err_o(err_w0), .busy_o(busy_w0)
   );

   lsu_mc #(.ADDR_W(32), .DEPTH_WORDS(512), .WAIT_CYCLES(3)) u_dut_w3 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(valid_w3), .req_ready_o(ready_w3),
      .req_we_i(we), .req_funct3_i(f3), .req_addr_i(addr), .req_wdata_i(wdata),
      .rsp_valid_o(rsp_v_w3), .rsp_rdata_o(rdata_w3), .rsp_err_o(err_w3), .busy_o(busy_w3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // One transaction on the WAIT_CYCLES=0 instance. Latency counts the accept
   // edge as 1, so an error response reads 1 and an aligned access reads 2.
   task automatic xact(input logic w, input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic e,
                       output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!ready_w0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      we = w; f3 = fn; addr = a; wdata = d; valid_w0 = 1'b1;
      @(posedge clk);
      #1;
      valid_w0 = 1'b0;
      lat = 1;
      while (!rsp_v_w0 && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      rd = rdata_w0;
      e  = err_w0;
   endtask

   task automatic run(input string tag, input logic w, input logic [2:0] fn,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
      logic [31:0] rd;
      logic        e;
      int          lat;
      xact(w, fn, a, d, rd, e, lat);
      check({tag, "_rdata"}, rd, exp_rd);
      check({tag, "_err"}, 32'(e), 32'(exp_err));
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; valid_w0 = 1'b0; valid_w3 = 1'b0;
      we = 1'b0; f3 = 3'b000; addr = 32'h0; wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(ready_w0), 32'd1);
      check("rst_valid", 32'(rsp_v_w0), 32'd0);
      check("rst_rdata", rdata_w0, 32'h0);
      check("rst_err", 32'(err_w0), 32'd0);
      check("rst_busy", 32'(busy_w0), 32'd0);
      check("rst_w3_ready", 32'(ready_w3), 32'd1);
      check("rst_w3_busy", 32'(busy_w3), 32'd0);
      rst = 1'b0;

      // Aligned word
      run("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
      run("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

      // Halfword / byte with extension; upper store-data bits must be ignored
      run("sh_22", 1'b1, 3'b001, 32'h22, 32'hFFFF8001, 32'h0, 1'b0, 2);
      run("lhu_22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0, 2);
      run("lh_22", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, 2);
      run("sb_21", 1'b1, 3'b000, 32'h21, 32'hABCDEFF0, 32'h0, 1'b0, 2);
      run("lb_21", 1'b0, 3'b000, 32'h21, 32'h0, 32'hFFFFFFF0, 1'b0, 2);
      run("lbu_21", 1'b0, 3'b100, 32'h21, 32'h0, 32'h000000F0, 1'b0, 2);
      run("lbu_22", 1'b0, 3'b100, 32'h22, 32'h0, 32'h00000001, 1'b0, 2);
      run("lbu_23", 1'b0, 3'b100, 32'h23, 32'h0, 32'h00000080, 1'b0, 2);

      // Known background for the misaligned and boundary cases
      run("sw_30", 1'b1, 3'b010, 32'h30, 32'hA0A1A2A3, 32'h0, 1'b0, 2);
      run("sw_34", 1'b1, 3'b010, 32'h34, 32'hB0B1B2B3, 32'h0, 1'b0, 2);
      run("sw_7fc", 1'b1, 3'b010, 32'h7FC, 32'h12345678, 32'h0, 1'b0, 2);

`ifdef LSU_MISALIGN_SPLIT_EN
      run("sw_33", 1'b1, 3'b010, 32'h33, 32'h11223344, 32'h0, 1'b0, 3);
      run("lbu_33", 1'b0, 3'b100, 32'h33, 32'h0, 32'h44, 1'b0, 2);
      run("lbu_34", 1'b0, 3'b100, 32'h34, 32'h0, 32'h33, 1'b0, 2);
      run("lbu_35", 1'b0, 3'b100, 32'h35, 32'h0, 32'h22, 1'b0, 2);
      run("lbu_36", 1'b0, 3'b100, 32'h36, 32'h0, 32'h11, 1'b0, 2);
      run("lw_33", 1'b0, 3'b010, 32'h33, 32'h0, 32'h11223344, 1'b0, 3);
      run("lw_30", 1'b0, 3'b010, 32'h30, 32'h0, 32'h44A1A2A3, 1'b0, 2);
      run("lw_34", 1'b0, 3'b010, 32'h34, 32'h0, 32'hB0112233, 1'b0, 2);
      run("lh_33", 1'b0, 3'b001, 32'h33, 32'h0, 32'h00003344, 1'b0, 3);
      run("lh_31", 1'b0, 3'b001, 32'h31, 32'h0, 32'hFFFFA1A2, 1'b0, 2);
`else
      run("sw_33", 1'b1, 3'b010, 32'h33, 32'h11223344, 32'h0, 1'b1, 1);
      run("lw_30", 1'b0, 3'b010, 32'h30, 32'h0, 32'hA0A1A2A3, 1'b0, 2);
      run("lw_34", 1'b0, 3'b010, 32'h34, 32'h0, 32'hB0B1B2B3, 1'b0, 2);
      run("lh_31", 1'b0, 3'b001, 32'h31, 32'h0, 32'h0, 1'b1, 1);
      run("lhu_33", 1'b0, 3'b101, 32'h33, 32'h0, 32'h0, 1'b1, 1);
      run("lw_32", 1'b0, 3'b010, 32'h32, 32'h0, 32'h0, 1'b1, 1);
`endif

      // Errors and range boundary
      run("sw_7fe", 1'b1, 3'b010, 32'h7FE, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
      run("lw_7fc", 1'b0, 3'b010, 32'h7FC, 32'h0, 32'h12345678, 1'b0, 2);
      run("lbu_7ff", 1'b0, 3'b100, 32'h7FF, 32'h0, 32'h00000012, 1'b0, 2);
      run("lw_800", 1'b0, 3'b010, 32'h800, 32'h0, 32'h0, 1'b1, 1);
      run("lw_top", 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 1);
      run("ld_f011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1);
      run("ld_f110", 1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, 1);
      run("st_f011", 1'b1, 3'b011, 32'h10, 32'h55555555, 32'h0, 1'b1, 1);
      run("st_f100", 1'b1, 3'b100, 32'h10, 32'h55555555, 32'h0, 1'b1, 1);
      run("lw_10_kept", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

      // Reset in the middle of a store
      run("sw_3c", 1'b1, 3'b010, 32'h3C, 32'h01020304, 32'h0, 1'b0, 2);
      run("sw_40", 1'b1, 3'b010, 32'h40, 32'h05060708, 32'h0, 1'b0, 2);
      repeat (2) @(negedge clk);
`ifdef LSU_MISALIGN_SPLIT_EN
      we = 1'b1; f3 = 3'b010; addr = 32'h3E; wdata = 32'hAABBCCDD; valid_w0 = 1'b1;
      @(posedge clk);
      #1 valid_w0 = 1'b0;
      @(negedge clk);
      check("mid_acc0_busy", 32'(busy_w0), 32'd1);
      @(negedge clk);
      check("mid_acc1_busy", 32'(busy_w0), 32'd1);
      check("mid_acc1_valid", 32'(rsp_v_w0), 32'd0);
      rst = 1'b1;
`else
      we = 1'b1; f3 = 3'b010; addr = 32'h3C; wdata = 32'hAABBCCDD; valid_w0 = 1'b1;
      @(posedge clk);
      #1 valid_w0 = 1'b0;
      @(negedge clk);
      check("mid_acc0_busy", 32'(busy_w0), 32'd1);
      rst = 1'b1;
`endif
      @(negedge clk);
      check("mid_rst_valid", 32'(rsp_v_w0), 32'd0);
      check("mid_rst_rdata", rdata_w0, 32'h0);
      check("mid_rst_err", 32'(err_w0), 32'd0);
      check("mid_rst_busy", 32'(busy_w0), 32'd0);
      check("mid_rst_ready", 32'(ready_w0), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_valid", 32'(rsp_v_w0), 32'd0);
`ifdef LSU_MISALIGN_SPLIT_EN
      run("lw_3c_after", 1'b0, 3'b010, 32'h3C, 32'h0, 32'hCCDD0304, 1'b0, 2);
`else
      run("lw_3c_after", 1'b0, 3'b010, 32'h3C, 32'h0, 32'h01020304, 1'b0, 2);
`endif
      run("lw_40_after", 1'b0, 3'b010, 32'h40, 32'h0, 32'h05060708, 1'b0, 2);

      // Handshake on the WAIT_CYCLES=3 instance with valid held high: a store,
      // then a load of the same word. Accepts every 6 cycles, response 5 after.
      @(negedge clk);
      check("hs_ready_0", 32'(ready_w3), 32'd1);
      we = 1'b1; f3 = 3'b010; addr = 32'h10; wdata = 32'hCAFEF00D; valid_w3 = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (n == 1) begin
            we = 1'b0;
            wdata = 32'h0;
         end
         check($sformatf("hs_ready_%0d", n), 32'(ready_w3), 32'((n % 6) == 0));
         check($sformatf("hs_valid_%0d", n), 32'(rsp_v_w3), 32'((n % 6) == 5));
         check($sformatf("hs_busy_%0d", n), 32'(busy_w3), 32'((n % 6) != 0));
         if (n == 5) begin
            check("hs_st_err", 32'(err_w3), 32'd0);
            check("hs_st_rdata", rdata_w3, 32'h0);
         end
         if (n == 11) begin
            check("hs_ld_err", 32'(err_w3), 32'd0);
            check("hs_ld_rdata", rdata_w3, 32'hCAFEF00D);
         end
      end
      valid_w3 = 1'b0;
      @(negedge clk);
      check("hs_idle_after", 32'(busy_w3), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
